// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the single-issue RV32I core. Owns the PC, presents
// the word index of the PC to the instruction memory and captures the returned
// word into the IF/ID register. It handles stall, flush and branch/jump
// redirect. A misaligned or out-of-range fetch address is a sticky fault; only
// reset leaves it.
//
// Ports
//   i_clk              clock, every state update is on its rising edge
//   i_rst              synchronous active-high reset, overrides all inputs
//   i_stall            hold the PC and the IF/ID register
//   i_flush            invalidate the IF/ID entry written this cycle
//   i_redirect_valid   taken branch/jump: load i_redirect_target into the PC
//   i_redirect_target  byte address of the redirect target
//   o_imem_addr        word index into imem, {2'b00, pc[31:2]} (combinational)
//   i_imem_rd          instruction word read back from imem (combinational)
//   o_if_instr         IF/ID instruction
//   o_if_pc            IF/ID byte PC of o_if_instr
//   o_if_pc_plus4      IF/ID o_if_pc + 4, modulo 2^32
//   o_if_valid         IF/ID entry valid
//   o_trap             sticky fetch fault
//   o_trap_pc          faulting byte address
//   o_fetch_count      number of captured instructions, wraps
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_redirect_valid,
    input  logic [31:0]      i_redirect_target,
    output logic [31:0]      o_imem_addr,
    input  logic [31:0]      i_imem_rd,
    output logic [31:0]      o_if_instr,
    output logic [31:0]      o_if_pc,
    output logic [31:0]      o_if_pc_plus4,
    output logic             o_if_valid,
    output logic             o_trap,
    output logic [31:0]      o_trap_pc,
    output logic [CNT_W-1:0] o_fetch_count
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DEPTH_W   = 32'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t            r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_if_instr;
    logic [31:0]       r_if_pc;
    logic [31:0]       r_if_pc_plus4;
    logic              r_if_valid;
    logic              r_trap;
    logic [31:0]       r_trap_pc;
    logic [CNT_W-1:0]  r_fetch_count;
    logic [31:0]       w_pc_plus4;

    // A fetch address is unusable when it is not word aligned or lies past the end of imem.
    function automatic logic addr_bad(input logic [31:0] a);
        addr_bad = (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= DEPTH_W);
    endfunction

    assign w_pc_plus4    = r_pc + 32'd4;
    assign o_imem_addr   = {2'b00, r_pc[31:2]};
    assign o_if_instr    = r_if_instr;
    assign o_if_pc       = r_if_pc;
    assign o_if_pc_plus4 = r_if_pc_plus4;
    assign o_if_valid    = r_if_valid;
    assign o_trap        = r_trap;
    assign o_trap_pc     = r_trap_pc;
    assign o_fetch_count = r_fetch_count;

    // PC sequencing, IF/ID capture and fault tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_if_instr    <= NOP_INSTR;
            r_if_pc       <= 32'h0000_0000;
            r_if_pc_plus4 <= 32'h0000_0000;
            r_if_valid    <= 1'b0;
            r_trap        <= 1'b0;
            r_trap_pc     <= 32'h0000_0000;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                // One settling cycle after reset: only the reset PC is vetted.
                ST_BOOT: begin
                    if (addr_bad(r_pc)) begin
                        r_state   <= ST_TRAP;
                        r_trap    <= 1'b1;
                        r_trap_pc <= r_pc;
                    end else begin
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_redirect_valid) begin
                        // Redirect wins over stall; the wrong-path entry is dropped.
                        r_if_valid <= 1'b0;
                        if (addr_bad(i_redirect_target)) begin
                            r_state   <= ST_TRAP;
                            r_trap    <= 1'b1;
                            r_trap_pc <= i_redirect_target;
                        end else begin
                            r_pc      <= i_redirect_target;
                        end
                    end else if (i_stall) begin
                        if (i_flush) begin
                            r_if_valid <= 1'b0;
                        end else begin
                            r_if_valid <= r_if_valid;
                        end
                    end else if (addr_bad(r_pc)) begin
                        // Sequential fetch ran off the end of imem.
                        r_state    <= ST_TRAP;
                        r_trap     <= 1'b1;
                        r_trap_pc  <= r_pc;
                        r_if_valid <= 1'b0;
                    end else begin
                        r_if_instr    <= i_imem_rd;
                        r_if_pc       <= r_pc;
                        r_if_pc_plus4 <= w_pc_plus4;
                        r_pc          <= w_pc_plus4;
                        r_if_valid    <= ~i_flush;
                        r_fetch_count <= r_fetch_count + CNT_W'(1);
                    end
                end
                ST_TRAP: begin
                    r_trap     <= 1'b1;
                    r_if_valid <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: fail safe into the fault state.
                    r_state    <= ST_TRAP;
                    r_trap     <= 1'b1;
                    r_trap_pc  <= r_pc;
                    r_if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int DEPTH = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, rv;
    logic [31:0] tgt;
    logic [31:0] imem_addr, imem_rd, if_instr, if_pc, if_pc4, trap_pc, cnt;
    logic        if_valid, trap;

    // Second instance with a tiny memory for the run-off-the-end case.
    logic        rst8;
    logic [31:0] imem_addr8, imem_rd8, if_instr8, if_pc8, if_pc48, trap_pc8, cnt8;
    logic        if_valid8, trap8;

    logic [31:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_rd  = (imem_addr  < DEPTH) ? mem[imem_addr[9:0]]  : 32'hDEAD_BEEF;
    assign imem_rd8 = (imem_addr8 < DEPTH) ? mem[imem_addr8[9:0]] : 32'hDEAD_BEEF;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
        .i_redirect_valid(rv), .i_redirect_target(tgt),
        .o_imem_addr(imem_addr), .i_imem_rd(imem_rd),
        .o_if_instr(if_instr), .o_if_pc(if_pc), .o_if_pc_plus4(if_pc4),
        .o_if_valid(if_valid), .o_trap(trap), .o_trap_pc(trap_pc),
        .o_fetch_count(cnt)
    );

    fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(8), .CNT_W(32)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_stall(1'b0), .i_flush(1'b0),
        .i_redirect_valid(1'b0), .i_redirect_target(32'h0),
        .o_imem_addr(imem_addr8), .i_imem_rd(imem_rd8),
        .o_if_instr(if_instr8), .o_if_pc(if_pc8), .o_if_pc_plus4(if_pc48),
        .o_if_valid(if_valid8), .o_trap(trap8), .o_trap_pc(trap_pc8),
        .o_fetch_count(cnt8)
    );

    typedef struct {
        logic        rst, stall, flush, rv;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_instr, e_pc, e_cnt;
        logic        e_trap;
        logic [31:0] e_tpc, e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] t, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep, input logic [31:0] ec, input logic et,
                       input logic [31:0] etp, input logic [31:0] ea);
        vec_t x;
        x.rst = r; x.stall = s; x.flush = f; x.rv = v; x.tgt = t;
        x.e_valid = ev; x.e_instr = ei; x.e_pc = ep; x.e_cnt = ec;
        x.e_trap = et; x.e_tpc = etp; x.e_addr = ea;
        vecs.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (spec-level rules) ----------------
    logic        m_boot, m_trapped, m_valid;
    logic [31:0] m_pc, m_instr, m_if_pc, m_if_pc4, m_tpc, m_cnt;

    function automatic bit fetch_ok(input logic [31:0] a, input int depth);
        return (a % 4 == 0) && ((a / 4) < depth);
    endfunction

    task automatic model_step;
        if (rst) begin
            m_boot = 1'b1; m_trapped = 1'b0; m_valid = 1'b0; m_pc = 32'h0;
            m_instr = NOP; m_if_pc = 32'h0; m_if_pc4 = 32'h0; m_tpc = 32'h0; m_cnt = 32'h0;
        end else if (m_trapped) begin
            m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (!fetch_ok(m_pc, DEPTH)) begin m_trapped = 1'b1; m_tpc = m_pc; end
        end else if (rv) begin
            m_valid = 1'b0;
            if (fetch_ok(tgt, DEPTH)) m_pc = tgt;
            else begin m_trapped = 1'b1; m_tpc = tgt; end
        end else if (stall) begin
            if (flush) m_valid = 1'b0;
        end else if (!fetch_ok(m_pc, DEPTH)) begin
            m_trapped = 1'b1; m_tpc = m_pc; m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc / 4];
            m_if_pc = m_pc;
            m_if_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            m_valid = !flush;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin
        logic [31:0] r;
        bit seen;

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h002082B3;
        mem[1] = 32'h00832383;
        mem[4] = 32'h0062E233;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; rv = 1'b0; tgt = 32'h0; rst8 = 1'b1;

        // ---------------- directed vector table ----------------
        //   rst stall flush rv  tgt     valid instr          pc      cnt  trap tpc    addr
        add(1, 0, 0, 0, 32'h0,  0, NOP,           32'h00, 32'd0, 0, 32'h00, 32'd0);
        add(1, 0, 0, 0, 32'h0,  0, NOP,           32'h00, 32'd0, 0, 32'h00, 32'd0);
        add(0, 0, 0, 0, 32'h0,  0, NOP,           32'h00, 32'd0, 0, 32'h00, 32'd0); // boot
        add(0, 0, 0, 0, 32'h0,  1, 32'h002082B3,  32'h00, 32'd1, 0, 32'h00, 32'd1);
        add(0, 0, 0, 0, 32'h0,  1, 32'h00832383,  32'h04, 32'd2, 0, 32'h00, 32'd2);
        add(0, 1, 0, 0, 32'h0,  1, 32'h00832383,  32'h04, 32'd2, 0, 32'h00, 32'd2); // stall x3
        add(0, 1, 0, 0, 32'h0,  1, 32'h00832383,  32'h04, 32'd2, 0, 32'h00, 32'd2);
        add(0, 1, 0, 0, 32'h0,  1, 32'h00832383,  32'h04, 32'd2, 0, 32'h00, 32'd2);
        add(0, 0, 0, 0, 32'h0,  1, 32'hA0000002,  32'h08, 32'd3, 0, 32'h00, 32'd3);
        add(0, 1, 0, 1, 32'h10, 0, 32'hA0000002,  32'h08, 32'd3, 0, 32'h00, 32'd4); // redirect+stall
        add(0, 0, 0, 0, 32'h0,  1, 32'h0062E233,  32'h10, 32'd4, 0, 32'h00, 32'd5);
        add(0, 0, 1, 0, 32'h0,  0, 32'hA0000005,  32'h14, 32'd5, 0, 32'h00, 32'd6); // flush on advance
        add(0, 0, 0, 0, 32'h0,  1, 32'hA0000006,  32'h18, 32'd6, 0, 32'h00, 32'd7);
        add(0, 1, 1, 0, 32'h0,  0, 32'hA0000006,  32'h18, 32'd6, 0, 32'h00, 32'd7); // flush while stalled
        add(0, 0, 0, 1, 32'h12, 0, 32'hA0000006,  32'h18, 32'd6, 1, 32'h12, 32'd7); // misaligned redirect
        add(0, 0, 0, 1, 32'h0,  0, 32'hA0000006,  32'h18, 32'd6, 1, 32'h12, 32'd7); // ignored
        add(0, 0, 0, 0, 32'h0,  0, 32'hA0000006,  32'h18, 32'd6, 1, 32'h12, 32'd7);
        add(1, 0, 0, 0, 32'h0,  0, NOP,           32'h00, 32'd0, 0, 32'h00, 32'd0);
        add(0, 0, 0, 0, 32'h0,  0, NOP,           32'h00, 32'd0, 0, 32'h00, 32'd0); // boot
        add(0, 0, 0, 0, 32'h0,  1, 32'h002082B3,  32'h00, 32'd1, 0, 32'h00, 32'd1);
        add(1, 1, 1, 1, 32'h40, 0, NOP,           32'h00, 32'd0, 0, 32'h00, 32'd0); // rst wins

        foreach (vecs[i]) begin
            rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
            rv = vecs[i].rv; tgt = vecs[i].tgt;
            tick();
            check($sformatf("v%0d.valid", i), 32'(if_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d.instr", i), if_instr, vecs[i].e_instr);
            check($sformatf("v%0d.if_pc", i), if_pc, vecs[i].e_pc);
            check($sformatf("v%0d.count", i), cnt, vecs[i].e_cnt);
            check($sformatf("v%0d.trap", i), 32'(trap), 32'(vecs[i].e_trap));
            check($sformatf("v%0d.trap_pc", i), trap_pc, vecs[i].e_tpc);
            check($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
        end

        // ---------------- randomized run against the model ----------------
        rst = 1'b1; stall = 1'b0; flush = 1'b0; rv = 1'b0; tgt = 32'h0;
        model_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 3) == 0);
            rv    = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 15);
            if (r == 0)      tgt = $urandom;
            else if (r == 1) tgt = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
            else if (r < 5)  tgt = $urandom_range(DEPTH - 8, DEPTH - 1) << 2;
            else             tgt = $urandom_range(0, DEPTH - 1) << 2;
            model_step();
            tick();
            check("rnd.valid", 32'(if_valid), 32'(m_valid));
            check("rnd.instr", if_instr, m_instr);
            check("rnd.if_pc", if_pc, m_if_pc);
            check("rnd.if_pc4", if_pc4, m_if_pc4);
            check("rnd.trap", 32'(trap), 32'(m_trapped));
            check("rnd.trap_pc", trap_pc, m_tpc);
            check("rnd.count", cnt, m_cnt);
            check("rnd.imem_addr", imem_addr, m_pc >> 2);
        end

        // ---------------- IMEM_DEPTH=8 free run ----------------
        rst8 = 1'b1;
        tick();
        check("d8.reset_trap", 32'(trap8), 32'd0);
        rst8 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (trap8) seen = 1'b1;
        end
        check("d8.trap_seen", 32'(seen), 32'd1);
        check("d8.trap_pc", trap_pc8, 32'h20);
        check("d8.count", cnt8, 32'd8);
        check("d8.valid", 32'(if_valid8), 32'd0);
        check("d8.last_if_pc", if_pc8, 32'h1C);
        check("d8.last_instr", if_instr8, 32'hA000_0007);
        tick();
        check("d8.trap_sticky", 32'(trap8), 32'd1);
        check("d8.count_held", cnt8, 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
